program_mem_responder: RTL and testbench
========================================

# program_mem_responder

Byte-wide unified instruction/data memory that sits on the far side of the 8-bit multicycle datapath's memory port. It answers `adr`/`memwrite`/`writedata` with `memdata`. It also contains a program-loader FSM that accepts 32-bit instruction words over a valid/ready handshake and writes each word as four consecutive bytes, low byte first. While a load is in progress, `busy` holds the core off the memory.

## Interface
- Parameters:
- `LOAD_BASE`, default 8'h00: byte address where the first loaded word is written.
- `MAX_WORDS`, default 64: word capacity of the loader (256 bytes / 4).
- Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `adr`  in  8: core byte address.
- `memwrite`  in  1: core write strobe.
- `writedata`  in  8: core write byte.
- `memdata`  out  8: read byte at `adr`.
- `ld_valid`  in  1: loader word available.
- `ld_word`  in  32: instruction word to load.
- `ld_last`  in  1: qualifies the final word of a program.
- `ld_ready`  out  1: loader can accept a word.
- `busy`  out  1: load in progress; the core must stall or stay in reset.
- `ld_count`  out  7: words accepted since reset, saturating at `MAX_WORDS`.
- `ld_err`  out  1: sticky overflow flag.

## Operation
- Storage: 256 x 8 array. Contents are not reset; a read of an unwritten byte returns X.
- Read path: `memdata` = mem[`adr`], combinational. The datapath registers it on the next edge.
- Core write: mem[`adr`] <= `writedata` on the rising edge when `memwrite`=1 and `busy`=0. When `busy`=1, the core write is ignored.
- FSM states and transitions:
- IDLE: `ld_ready`=1.
  - On `ld_valid`&`ld_ready`: if `ld_count` < `MAX_WORDS`, capture `ld_word` and `ld_last`, increment `ld_count`, go to WB0.
  - Otherwise set `ld_err`, drop the word, and stay in IDLE.
- WB0..WB3: write mem[`ld_ptr`+k] <= `ld_word`[8k+7:8k] in state WBk. `ld_ptr` increments by 1 each byte, 8-bit wrap.
- After WB3: go to IDLE.
- Byte order: lowest address holds bits 7:0, matching the datapath's fetch order (`irwrite[0]` loads `instr[7:0]` first).
- `busy`:
- Set on the first word accepted.
- Held until the WB3 of a word captured with `ld_last`=1; cleared on that edge.
- A non-last word leaves `busy`=1 while the FSM is back in IDLE waiting for more words.
- Reset (any time, including mid-load):
- FSM goes to IDLE, `ld_ptr`=`LOAD_BASE`, `ld_count`=0, `ld_err`=0, `busy`=0, `ld_ready`=1.
- Bytes already written are retained; the partial word stays partial.

## Timing
- Load latency: one accepted word occupies 4 cycles (WB0..WB3) after the accept edge. `ld_ready` is low for those 4 cycles.
- Maximum throughput: one word per 5 cycles.
- Read latency: 0 cycles, combinational from `adr`.
- Read-during-write to the same address: `memdata` shows the old value until the edge and the new value after it.
- Simultaneous loader byte write and core `memwrite`: the loader always wins, because `busy` gates the core.
- `ld_err` rises on the edge of the rejected handshake and stays high until reset.
- `ld_count` updates on the accept edge.

## Structure
- Shared package `memresp_pkg`:
  - FSM state enum {IDLE, WB0, WB1, WB2, WB3};
  - `MEM_DEPTH`=256;
  - byte and address widths.
- Sub-module `mem_bytearray`: 256 x 8 array with one write port (addr, data, we) and one asynchronous read port.
- The top level muxes the write port between the loader and the core.

## Test plan
- Reset, then load one word 32'hAABBCCDD with `ld_last`=1, `LOAD_BASE`=0 -> after 4 cycles, mem[0..3] = DD, CC, BB, AA; `busy` 1->0; `ld_count`=1.
- Load three words with `ld_last` on the third -> `busy` stays 1 between words. Reads at `adr`=8..11 return the third word's bytes, low byte first. `ld_ready` is low exactly 4 cycles per word.
- Core `memwrite`=1, `adr`=8'h20, `writedata`=8'h5A with `busy`=0 -> `memdata` reads 5A at `adr`=20 after the edge. Repeat with `busy`=1 -> mem[20] is unchanged.
- Load 64 words, then assert `ld_valid` again -> `ld_err`=1, `ld_count`=64, mem[0..3] are not overwritten.
- Assert `reset`=0 during WB2 of word 32'h11223344 -> mem[0..1] = 44, 33 and mem[2..3] are unwritten. All outputs return to reset values; the next load starts at `LOAD_BASE`.
- Set `LOAD_BASE`=8'hFE and load two words -> the byte pointer wraps: mem[FE], mem[FF], mem[00], mem[01] hold the first word. No error is flagged.

Source files
------------

// File: rtl/memresp_pkg.sv
// Shared types and sizes for the program memory responder: loader FSM states
// and the byte/address/word widths of the unified memory.
package memresp_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int COUNT_W   = 7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB0  = 3'd1,
        WB1  = 3'd2,
        WB2  = 3'd3,
        WB3  = 3'd4
    } ld_state_t;

endpackage

// File: rtl/mem_bytearray.sv
// 256 x 8 storage with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset so a reset never destroys a loaded program.
module mem_bytearray
    import memresp_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BYTE_W-1:0] data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_mem_responder.sv
// Unified byte memory for the 8-bit multicycle core, plus a loader FSM that
// writes 32-bit words as four bytes (low byte first) while holding the core off.
module program_mem_responder
    import memresp_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LOAD_BASE = 8'h00,
    parameter int                MAX_WORDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  adr,
    input  logic               memwrite,
    input  logic [BYTE_W-1:0]  writedata,
    output logic [BYTE_W-1:0]  memdata,
    input  logic               ld_valid,
    input  logic [WORD_W-1:0]  ld_word,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] ld_count,
    output logic               ld_err
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_WORDS);

    ld_state_t         state;
    ld_state_t         state_next;
    logic [WORD_W-1:0] word_q;
    logic              last_q;
    logic [ADDR_W-1:0] ld_ptr;
    logic              ld_we;
    logic [BYTE_W-1:0] ld_byte;
    logic              room;
    logic              accept;
    logic              wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [BYTE_W-1:0] wr_data;

    assign room   = (ld_count < COUNT_MAX);
    assign accept = ld_valid && ld_ready;

    // Handshake: a word transfers on a rising edge where ld_valid and ld_ready are both 1.
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        ld_we      = 1'b0;
        ld_byte    = '0;
        unique case (state)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid && room) begin
                    state_next = WB0;
                end
            end
            WB0: begin
                ld_we      = 1'b1;
                ld_byte    = word_q[7:0];
                state_next = WB1;
            end
            WB1: begin
                ld_we      = 1'b1;
                ld_byte    = word_q[15:8];
                state_next = WB2;
            end
            WB2: begin
                ld_we      = 1'b1;
                ld_byte    = word_q[23:16];
                state_next = WB3;
            end
            WB3: begin
                ld_we      = 1'b1;
                ld_byte    = word_q[31:24];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rejected word only raises ld_err; it never starts a write burst or sets busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q   <= '0;
            last_q   <= 1'b0;
            ld_ptr   <= LOAD_BASE;
            ld_count <= '0;
            ld_err   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (accept) begin
                if (room) begin
                    word_q   <= ld_word;
                    last_q   <= ld_last;
                    ld_count <= ld_count + 1'b1;
                    busy     <= 1'b1;
                end else begin
                    ld_err <= 1'b1;
                end
            end
            if (ld_we) begin
                ld_ptr <= ld_ptr + 1'b1;
            end
            if (state == WB3 && last_q) begin
                busy <= 1'b0;
            end
        end
    end

    // Loader owns the write port whenever it is writing; busy also masks the core.
    assign wr_we   = ld_we || (memwrite && !busy);
    assign wr_addr = ld_we ? ld_ptr  : adr;
    assign wr_data = ld_we ? ld_byte : writedata;

    mem_bytearray u_mem (
        .clk     (clk),
        .we      (wr_we),
        .addr    (wr_addr),
        .data    (wr_data),
        .rd_addr (adr),
        .rd_data (memdata)
    );

endmodule

// File: tb/tb_program_mem_responder.sv
// Directed bench for program_mem_responder: a base-0 instance and a base-FE instance,
// expected values queued by the stimulus and compared by a negedge monitor.
module tb_program_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [7:0]  adr_a, writedata_a, memdata_a;
    logic        memwrite_a, ld_valid_a, ld_last_a, ld_ready_a, busy_a, ld_err_a;
    logic [31:0] ld_word_a;
    logic [6:0]  ld_count_a;

    logic [7:0]  adr_b, writedata_b, memdata_b;
    logic        memwrite_b, ld_valid_b, ld_last_b, ld_ready_b, busy_b, ld_err_b;
    logic [31:0] ld_word_b;
    logic [6:0]  ld_count_b;

    program_mem_responder #(.LOAD_BASE(8'h00), .MAX_WORDS(64)) dut (
        .clk(clk), .reset(reset), .adr(adr_a), .memwrite(memwrite_a),
        .writedata(writedata_a), .memdata(memdata_a), .ld_valid(ld_valid_a),
        .ld_word(ld_word_a), .ld_last(ld_last_a), .ld_ready(ld_ready_a),
        .busy(busy_a), .ld_count(ld_count_a), .ld_err(ld_err_a)
    );

    program_mem_responder #(.LOAD_BASE(8'hFE), .MAX_WORDS(64)) dut_fe (
        .clk(clk), .reset(reset), .adr(adr_b), .memwrite(memwrite_b),
        .writedata(writedata_b), .memdata(memdata_b), .ld_valid(ld_valid_b),
        .ld_word(ld_word_b), .ld_last(ld_last_b), .ld_ready(ld_ready_b),
        .busy(busy_b), .ld_count(ld_count_b), .ld_err(ld_err_b)
    );

    // Selectors: 0..4 = instance A memdata/busy/ld_count/ld_err/ld_ready, 10..14 = instance B.
    localparam int S_MEM = 0, S_BUSY = 1, S_CNT = 2, S_ERR = 3, S_RDY = 4;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q[$];
    int          sel_q[$];
    bit          neq_q[$];
    string       name_q[$];

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0:  return {24'h0, memdata_a};
            1:  return {31'h0, busy_a};
            2:  return {25'h0, ld_count_a};
            3:  return {31'h0, ld_err_a};
            4:  return {31'h0, ld_ready_a};
            10: return {24'h0, memdata_b};
            11: return {31'h0, busy_b};
            12: return {25'h0, ld_count_b};
            13: return {31'h0, ld_err_b};
            14: return {31'h0, ld_ready_b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic expect_sig(int which, int sel, logic [31:0] val, string name, bit neq = 1'b0);
        exp_q.push_back(val);
        sel_q.push_back(which * 10 + sel);
        neq_q.push_back(neq);
        name_q.push_back(name);
    endtask

    logic [31:0] m_exp, m_act;
    int          m_sel;
    bit          m_neq;
    string       m_name;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_sel  = sel_q.pop_front();
            m_neq  = neq_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = observe(m_sel);
            n_total++;
            if (m_neq ? (m_act !== m_exp) : (m_act === m_exp)) n_pass++;
            else if (m_neq) $display("FAIL %s: got %0h, required anything but %0h", m_name, m_act, m_exp);
            else $display("FAIL %s: got %0h, required %0h", m_name, m_act, m_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(int which);
        return (which == 0) ? ld_ready_a : ld_ready_b;
    endfunction

    task automatic set_ld(int which, logic v, logic [31:0] w, logic l);
        if (which == 0) begin
            ld_valid_a = v; ld_word_a = w; ld_last_a = l;
        end else begin
            ld_valid_b = v; ld_word_b = w; ld_last_b = l;
        end
    endtask

    task automatic rd(int which, logic [7:0] a, logic [7:0] e, string name, bit neq = 1'b0);
        if (which == 0) adr_a = a;
        else adr_b = a;
        expect_sig(which, S_MEM, {24'h0, e}, name, neq);
        step();
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    // Offer one word, expect it accepted, then measure the ld_ready-low window.
    task automatic send(int which, logic [31:0] w, logic l, logic [6:0] cnt);
        int n;
        int lo;
        set_ld(which, 1'b1, w, l);
        n = 0;
        while (!rdy(which) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check($sformatf("ld_ready_wait_%h", w), {31'h0, rdy(which)}, 32'h1);
        step();
        set_ld(which, 1'b0, 32'h0, 1'b0);
        expect_sig(which, S_BUSY, 32'h1, $sformatf("busy_during_%h", w));
        expect_sig(which, S_CNT, {25'h0, cnt}, $sformatf("ld_count_after_%h", w));
        lo = 0;
        while (!rdy(which) && lo < 10) begin
            lo++;
            step();
        end
        check($sformatf("ld_ready_low_cycles_%h", w), lo, 4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        adr_a = 8'h0; writedata_a = 8'h0; memwrite_a = 1'b0;
        adr_b = 8'h0; writedata_b = 8'h0; memwrite_b = 1'b0;
        set_ld(0, 1'b0, 32'h0, 1'b0);
        set_ld(1, 1'b0, 32'h0, 1'b0);
        step();
        step();
        reset = 1'b1;
        expect_sig(0, S_BUSY, 32'h0, "reset_busy");
        expect_sig(0, S_CNT, 32'h0, "reset_ld_count");
        expect_sig(0, S_ERR, 32'h0, "reset_ld_err");
        expect_sig(0, S_RDY, 32'h1, "reset_ld_ready");
        step();

        // Reset lands in WB2: bytes 0,1 written, bytes 2,3 never written.
        set_ld(0, 1'b1, 32'h11223344, 1'b1);
        step();
        set_ld(0, 1'b0, 32'h0, 1'b0);
        step();
        step();
        reset = 1'b0;
        expect_sig(0, S_BUSY, 32'h0, "midload_reset_busy");
        expect_sig(0, S_CNT, 32'h0, "midload_reset_ld_count");
        expect_sig(0, S_ERR, 32'h0, "midload_reset_ld_err");
        expect_sig(0, S_RDY, 32'h1, "midload_reset_ld_ready");
        step();
        rd(0, 8'h00, 8'h44, "partial_mem0");
        rd(0, 8'h01, 8'h33, "partial_mem1");
        rd(0, 8'h02, 8'h22, "partial_mem2_unwritten", 1'b1);
        rd(0, 8'h03, 8'h11, "partial_mem3_unwritten", 1'b1);
        reset = 1'b1;
        step();

        // Single last word from LOAD_BASE.
        send(0, 32'hAABBCCDD, 1'b1, 7'd1);
        expect_sig(0, S_BUSY, 32'h0, "single_busy_cleared");
        rd(0, 8'h00, 8'hDD, "single_mem0");
        rd(0, 8'h01, 8'hCC, "single_mem1");
        rd(0, 8'h02, 8'hBB, "single_mem2");
        rd(0, 8'h03, 8'hAA, "single_mem3");

        // Three-word program: busy holds between words.
        reset_pulse();
        send(0, 32'h01020304, 1'b0, 7'd1);
        expect_sig(0, S_BUSY, 32'h1, "multi_busy_gap1");
        send(0, 32'h05060708, 1'b0, 7'd2);
        expect_sig(0, S_BUSY, 32'h1, "multi_busy_gap2");
        expect_sig(0, S_RDY, 32'h1, "multi_ready_gap2");
        send(0, 32'h090A0B0C, 1'b1, 7'd3);
        expect_sig(0, S_BUSY, 32'h0, "multi_busy_cleared");
        rd(0, 8'h04, 8'h08, "multi_mem4");
        rd(0, 8'h07, 8'h05, "multi_mem7");
        rd(0, 8'h08, 8'h0C, "multi_mem8");
        rd(0, 8'h09, 8'h0B, "multi_mem9");
        rd(0, 8'h0A, 8'h0A, "multi_mem10");
        rd(0, 8'h0B, 8'h09, "multi_mem11");

        // Core write allowed when idle, ignored while busy.
        adr_a = 8'h20; writedata_a = 8'h5A; memwrite_a = 1'b1;
        step();
        memwrite_a = 1'b0;
        rd(0, 8'h20, 8'h5A, "core_write_idle");
        send(0, 32'hDEADBEEF, 1'b0, 7'd4);
        adr_a = 8'h20; writedata_a = 8'hA5; memwrite_a = 1'b1;
        expect_sig(0, S_BUSY, 32'h1, "core_write_busy_flag");
        step();
        memwrite_a = 1'b0;
        rd(0, 8'h20, 8'h5A, "core_write_blocked");
        rd(0, 8'h0C, 8'hEF, "nonlast_mem12");
        rd(0, 8'h0F, 8'hDE, "nonlast_mem15");

        // Fill all 64 words (mem[k] = k), then one more word is rejected.
        reset_pulse();
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b0;
            b0 = 8'(4 * i);
            send(0, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, (i == 63), 7'(i + 1));
        end
        expect_sig(0, S_ERR, 32'h0, "full_no_err_yet");
        expect_sig(0, S_BUSY, 32'h0, "full_busy_cleared");
        set_ld(0, 1'b1, 32'hFFFFFFFF, 1'b1);
        step();
        set_ld(0, 1'b0, 32'h0, 1'b0);
        expect_sig(0, S_ERR, 32'h1, "overflow_ld_err");
        expect_sig(0, S_CNT, 32'd64, "overflow_ld_count");
        expect_sig(0, S_RDY, 32'h1, "overflow_stays_idle");
        expect_sig(0, S_BUSY, 32'h0, "overflow_no_busy");
        step();
        rd(0, 8'h00, 8'h00, "overflow_mem0");
        rd(0, 8'h01, 8'h01, "overflow_mem1");
        rd(0, 8'h02, 8'h02, "overflow_mem2");
        rd(0, 8'h03, 8'h03, "overflow_mem3");
        rd(0, 8'hFF, 8'hFF, "full_mem255");
        expect_sig(0, S_ERR, 32'h1, "overflow_err_sticky");
        step();

        // Base FE: the byte pointer wraps through 00.
        send(1, 32'hD4C3B2A1, 1'b0, 7'd1);
        send(1, 32'h88776655, 1'b1, 7'd2);
        expect_sig(1, S_ERR, 32'h0, "wrap_no_err");
        expect_sig(1, S_BUSY, 32'h0, "wrap_busy_cleared");
        expect_sig(1, S_CNT, 32'd2, "wrap_ld_count");
        step();
        rd(1, 8'hFE, 8'hA1, "wrap_memFE");
        rd(1, 8'hFF, 8'hB2, "wrap_memFF");
        rd(1, 8'h00, 8'hC3, "wrap_mem00");
        rd(1, 8'h01, 8'hD4, "wrap_mem01");
        rd(1, 8'h02, 8'h55, "wrap_mem02");
        rd(1, 8'h05, 8'h88, "wrap_mem05");

        step();
        step();
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
